mips_main_control: RTL and testbench
====================================

// Module: mips_main_control
// PURPOSE
//  Multi-cycle main control FSM for the MIPS datapath. Decodes the instruction
//  opcode (IR[31:26]) and drives the datapath strobes and the 3-bit aluOp code
//  consumed by the registered ALU control stage (producer side of aluOp).
//  Handshakes with unified memory via mem_ready; stalls FETCH/MEMACC until ready.
// PARAMETERS
//  CNT_W  16  width of retired-instruction counter
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  rst_n       in   1      asynchronous, active-low reset
//  opcode      in   6      IR[31:26], stable from DECODE until next FETCH
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory access completes this cycle
//  mem_read    out  1      memory read strobe (fetch or lw)
//  mem_write   out  1      memory write strobe (sw)
//  ir_write    out  1      load IR
//  pc_write    out  1      load PC
//  pc_src      out  2      00 ALU result, 01 ALUOut, 10 jump target
//  alu_src_a   out  1      0 PC, 1 rs
//  alu_src_b   out  2      00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  reg_write   out  1      register file write
//  reg_dst     out  1      1 rd, 0 rt
//  mem_to_reg  out  1      1 MDR, 0 ALUOut
//  aluOp       out  3      ALU op code, look-ahead (see below)
//  instr_done  out  1      one-cycle pulse when an instruction retires
//  illegal_op  out  1      one-cycle pulse on unknown opcode
//  retired     out  CNT_W  retired-instruction count, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, retired=0; all outputs 0 while rst_n low; release mid-
//   instruction aborts it (no completion, no strobes carried over).
//  Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101,
//   addi 001000, andi 001100, ori 001101, j 000010; anything else illegal.
//  States (3b): FETCH 0, DECODE 1, EXEC 2, MEMACC 3, WB 4, BRANCH 5, JUMP 6.
//  FETCH: mem_read=1, alu_src_b=01; stay until mem_ready; on mem_ready cycle
//   ir_write=1, pc_write=1, pc_src=00 -> DECODE.
//  DECODE: alu_src_b=11; R/lw/sw/addi/andi/ori -> EXEC; beq/bne -> BRANCH;
//   j -> JUMP; illegal -> illegal_op=1 -> FETCH (not counted).
//  EXEC: alu_src_a=1; alu_src_b=00 R, 10 otherwise; lw/sw -> MEMACC, else WB.
//  MEMACC: lw mem_read=1, sw mem_write=1; hold until mem_ready;
//   lw -> WB; sw -> instr_done=1 -> FETCH.
//  WB: reg_write=1; reg_dst=1 for R; mem_to_reg=1 for lw; instr_done=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, pc_src=01;
//   pc_write=(beq&zero)|(bne&~zero); instr_done=1 -> FETCH.
//  JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
//  Unlisted outputs are 0 in each state; Moore except FETCH/MEMACC/BRANCH
//   strobes gated by mem_ready/zero as stated.
//  aluOp: ALU control registers aluOp, so aluOp = code(next_state, opcode):
//   EXEC R 010, lw/sw 000, addi 101, andi 100, ori 110; BRANCH beq 001,
//   bne 111; every other next state 000. Stall cycles repeat same code.
//  retired += 1 on each instr_done (same edge), wraps to 0 from all-ones.
// TESTING
//  R add: FETCH ready 1 cyc -> DECODE,EXEC,WB; aluOp=010 in DECODE; reg_dst=1,
//   reg_write=1, instr_done in WB; retired 0->1.
//  lw with mem_ready low 3 cycles in MEMACC -> mem_read held 4 cycles, then WB
//   with mem_to_reg=1; sw ends in MEMACC with instr_done, no WB.
//  beq zero=1 -> pc_write=1,pc_src=01; bne zero=1 -> pc_write=0; aluOp 001/111
//   during DECODE respectively.
//  opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, retired unchanged.
//  rst_n low mid-MEMACC of sw -> mem_write=0 immediately; restart in FETCH.
//  CNT_W=4, retire 16 instrs -> retired wraps 15->0.

Source files
------------

// File: rtl/mips_main_control.sv
// Multi-cycle main control FSM for the MIPS datapath: opcode decode, datapath
// strobes, look-ahead aluOp for the registered ALU control, retired counter.
module mips_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [2:0]       aluOp,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  // state   | meaning
  // FETCH   | read instruction, PC += 4 when memory ready
  // DECODE  | register read, branch target precompute, opcode dispatch
  // EXEC    | ALU operation (R-type, immediate, address calc)
  // MEMACC  | lw read / sw write, held until memory ready
  // WB      | register file write
  // BRANCH  | compare rs/rt, conditional PC update
  // JUMP    | PC <= jump target
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMACC = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state, next_state;

  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_andi, is_ori, is_j;
  logic is_alu_class;

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_addi = (opcode == OP_ADDI);
  assign is_andi = (opcode == OP_ANDI);
  assign is_ori  = (opcode == OP_ORI);
  assign is_j    = (opcode == OP_J);
  assign is_alu_class = is_r | is_lw | is_sw | is_addi | is_andi | is_ori;

  logic       mem_read_c, mem_write_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c, alu_src_b_c;
  logic       alu_src_a_c, reg_write_c, reg_dst_c, mem_to_reg_c;
  logic [2:0] alu_op_c;
  logic       instr_done_c, illegal_op_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    instr_done_c = 1'b0;
    illegal_op_c = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        if (is_alu_class)           next_state = S_EXEC;
        else if (is_beq || is_bne)  next_state = S_BRANCH;
        else if (is_j)              next_state = S_JUMP;
        else begin
          illegal_op_c = 1'b1;
          next_state   = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = is_r ? 2'b00 : 2'b10;
        next_state  = (is_lw || is_sw) ? S_MEMACC : S_WB;
      end
      S_MEMACC: begin
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_ready) begin
          instr_done_c = is_sw;
          next_state   = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = is_r;
        mem_to_reg_c = is_lw;
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c  = 1'b1;
        pc_src_c     = 2'b01;
        pc_write_c   = (is_beq & zero) | (is_bne & ~zero);
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c     = 2'b10;
        pc_write_c   = 1'b1;
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // ALU control registers aluOp, so the code tracks the state being entered.
  always_comb begin
    alu_op_c = 3'b000;
    if (next_state == S_EXEC) begin
      if (is_r)         alu_op_c = 3'b010;
      else if (is_addi) alu_op_c = 3'b101;
      else if (is_andi) alu_op_c = 3'b100;
      else if (is_ori)  alu_op_c = 3'b110;
    end else if (next_state == S_BRANCH) begin
      if (is_beq)       alu_op_c = 3'b001;
      else if (is_bne)  alu_op_c = 3'b111;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            retired <= '0;
    else if (instr_done_c) retired <= retired + CNT_W'(1);
  end

  assign mem_read   = rst_n & mem_read_c;
  assign mem_write  = rst_n & mem_write_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign pc_src     = rst_n ? pc_src_c : 2'b00;
  assign alu_src_a  = rst_n & alu_src_a_c;
  assign alu_src_b  = rst_n ? alu_src_b_c : 2'b00;
  assign reg_write  = rst_n & reg_write_c;
  assign reg_dst    = rst_n & reg_dst_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign aluOp      = rst_n ? alu_op_c : 3'b000;
  assign instr_done = rst_n & instr_done_c;
  assign illegal_op = rst_n & illegal_op_c;

endmodule

// File: tb/tb_mips_main_control.sv
// Directed bench for mips_main_control: per-instruction phase model checked
// every cycle, plus literal spot checks on key behaviours.
module tb_mips_main_control;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic mem_read, mem_write, ir_write, pc_write, alu_src_a;
  logic reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] aluOp;
  logic [CNT_W-1:0] retired;

  mips_main_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .aluOp(aluOp),
    .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr, mw, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic       rw, rd, m2r;
    logic [2:0] op;
    logic       done, ill;
  } ov_t;

  ov_t act;
  assign act = {mem_read, mem_write, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, reg_write, reg_dst, mem_to_reg, aluOp, instr_done,
                illegal_op};

  int vecs = 0;
  int errs = 0;
  ov_t exp_o;
  logic [CNT_W-1:0] exp_ret;
  logic chk_en = 1'b0;
  int phase = 0;
  logic [2:0] dec_aluop;
  logic dec_ill, br_pcw;
  int mem_rd_cyc;

  always @(negedge clk) begin
    if (chk_en) begin
      vecs++;
      if (act !== exp_o) begin
        errs++;
        $display("FAIL outputs phase=%0d actual=%b required=%b", phase, act, exp_o);
      end
      vecs++;
      if (retired !== exp_ret) begin
        errs++;
        $display("FAIL retired phase=%0d actual=%0d required=%0d", phase, retired, exp_ret);
      end
      case (phase)
        1: begin dec_aluop = aluOp; dec_ill = illegal_op; end
        2: if (mem_read) mem_rd_cyc++;
        3: br_pcw = pc_write;
        default: ;
      endcase
    end
  end

  task automatic lit(input string name, input logic [31:0] a, input logic [31:0] r);
    vecs++;
    if (a !== r) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, a, r);
    end
  endtask

  function automatic logic known(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
  endfunction

  function automatic logic [2:0] dec_code(input logic [5:0] op);
    case (op)
      OP_R:    return 3'b010;
      OP_ADDI: return 3'b101;
      OP_ANDI: return 3'b100;
      OP_ORI:  return 3'b110;
      OP_BEQ:  return 3'b001;
      OP_BNE:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ov_t e_fetch(input logic rdy);
    ov_t e = '0;
    e.mr = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy;
    return e;
  endfunction

  function automatic ov_t e_decode(input logic [5:0] op);
    ov_t e = '0;
    e.asb = 2'b11; e.op = dec_code(op); e.ill = !known(op);
    return e;
  endfunction

  function automatic ov_t e_exec(input logic [5:0] op);
    ov_t e = '0;
    e.asa = 1'b1; e.asb = (op == OP_R) ? 2'b00 : 2'b10;
    return e;
  endfunction

  function automatic ov_t e_mem(input logic [5:0] op, input logic rdy);
    ov_t e = '0;
    e.mr = (op == OP_LW); e.mw = (op == OP_SW); e.done = (op == OP_SW) && rdy;
    return e;
  endfunction

  function automatic ov_t e_wb(input logic [5:0] op);
    ov_t e = '0;
    e.rw = 1'b1; e.rd = (op == OP_R); e.m2r = (op == OP_LW); e.done = 1'b1;
    return e;
  endfunction

  function automatic ov_t e_branch(input logic [5:0] op, input logic z);
    ov_t e = '0;
    e.asa = 1'b1; e.pcs = 2'b01; e.done = 1'b1;
    e.pcw = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
    return e;
  endfunction

  function automatic ov_t e_jump();
    ov_t e = '0;
    e.pcs = 2'b10; e.pcw = 1'b1; e.done = 1'b1;
    return e;
  endfunction

  // Called just after a rising edge; expectations cover the cycle up to the next one.
  task automatic cyc(input ov_t e, input logic rdy, input logic z, input int ph);
    mem_ready = rdy;
    zero      = z;
    exp_o     = e;
    phase     = ph;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
    if (e.done) exp_ret = exp_ret + 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    opcode = op;
    mem_rd_cyc = 0;
    for (int i = 0; i <= fw; i++) cyc(e_fetch(i == fw), i == fw, z, 0);
    cyc(e_decode(op), 1'b0, z, 1);
    if (!known(op)) return;
    if (op == OP_BEQ || op == OP_BNE) cyc(e_branch(op, z), 1'b0, z, 3);
    else if (op == OP_J) cyc(e_jump(), 1'b0, z, 0);
    else begin
      cyc(e_exec(op), 1'b0, z, 0);
      if (op == OP_LW || op == OP_SW)
        for (int i = 0; i <= mw; i++) cyc(e_mem(op, i == mw), i == mw, z, 2);
      if (op != OP_SW) cyc(e_wb(op), 1'b0, z, 0);
    end
  endtask

  initial begin
    rst_n = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = OP_R; exp_ret = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_outputs", 32'(act), 32'd0);
    lit("reset_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;

    run_instr(OP_R, 0, 0, 1'b0);
    lit("r_decode_aluop", 32'(dec_aluop), 32'b010);
    lit("r_retired", 32'(retired), 32'd1);

    run_instr(OP_LW, 2, 3, 1'b0);
    lit("lw_mem_read_cycles", 32'(mem_rd_cyc), 32'd4);
    run_instr(OP_SW, 0, 1, 1'b0);
    lit("sw_retired", 32'(retired), 32'd3);

    run_instr(OP_BEQ, 0, 0, 1'b1);
    lit("beq_z1_pc_write", 32'(br_pcw), 32'd1);
    lit("beq_decode_aluop", 32'(dec_aluop), 32'b001);
    run_instr(OP_BNE, 1, 0, 1'b1);
    lit("bne_z1_pc_write", 32'(br_pcw), 32'd0);
    lit("bne_decode_aluop", 32'(dec_aluop), 32'b111);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_BNE, 0, 0, 1'b0);
    lit("bne_z0_pc_write", 32'(br_pcw), 32'd1);

    run_instr(OP_ADDI, 0, 0, 1'b0);
    lit("addi_decode_aluop", 32'(dec_aluop), 32'b101);
    run_instr(OP_ANDI, 0, 0, 1'b0);
    run_instr(OP_ORI, 0, 0, 1'b0);
    lit("ori_decode_aluop", 32'(dec_aluop), 32'b110);
    run_instr(OP_J, 0, 0, 1'b0);

    run_instr(6'b111111, 0, 0, 1'b0);
    lit("illegal_pulse", 32'(dec_ill), 32'd1);
    lit("illegal_retired", 32'(retired), 32'd11);
    run_instr(6'b000001, 1, 0, 1'b0);

    for (int k = 0; k < 4; k++) run_instr(OP_R, 0, 0, 1'b0);
    lit("retired_max", 32'(retired), 32'd15);
    run_instr(OP_R, 0, 0, 1'b0);
    lit("retired_wrap", 32'(retired), 32'd0);

    // Abort an sw while it is stalled in the memory access.
    opcode = OP_SW;
    cyc(e_fetch(1'b1), 1'b1, 1'b0, 0);
    cyc(e_decode(OP_SW), 1'b0, 1'b0, 1);
    cyc(e_exec(OP_SW), 1'b0, 1'b0, 0);
    cyc(e_mem(OP_SW, 1'b0), 1'b0, 1'b0, 2);
    cyc(e_mem(OP_SW, 1'b0), 1'b0, 1'b0, 2);
    chk_en = 1'b0;
    #1;
    lit("sw_mem_write_before_rst", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    lit("rst_mid_outputs", 32'(act), 32'd0);
    lit("rst_mid_mem_write", 32'(mem_write), 32'd0);
    lit("rst_mid_retired", 32'(retired), 32'd0);
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr(OP_R, 0, 0, 1'b0);
    lit("after_rst_retired", 32'(retired), 32'd1);
    run_instr(OP_LW, 0, 0, 1'b0);
    lit("after_rst_lw_retired", 32'(retired), 32'd2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
